// File: rtl/mod_sub_pipe.sv
// Two-stage modular subtractor z = (a - b) mod m (m=0 means 2^WIDTH); 2-cycle latency, valid/ready with a skid-free stall.
// Optional MOD_RANGE_CHECK_EN adds err, flagging operands outside [0, m) for m != 0.
module mod_sub_pipe #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z
`ifdef MOD_RANGE_CHECK_EN
  ,
  output logic             err
`endif
);

  logic             r_s1_v;
  logic [WIDTH:0]   r_s1_diff;
  logic [WIDTH-1:0] r_s1_wrap;
  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_wrap;
  logic             w_s2_load;
  logic             w_s1_adv;

  assign w_diff    = {1'b0, a} - {1'b0, b};
  assign w_wrap    = w_diff[WIDTH-1:0] + m;
  assign w_s2_load = !out_valid || out_ready;
  assign w_s1_adv  = !r_s1_v || w_s2_load;
  assign in_ready  = w_s1_adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_v    <= 1'b0;
      r_s1_diff <= '0;
      r_s1_wrap <= '0;
    end else if (w_s1_adv) begin
      r_s1_v <= in_valid;
      if (in_valid) begin
        r_s1_diff <= w_diff;
        r_s1_wrap <= w_wrap;
      end
    end
  end

  // The borrow bit selects the wrapped value; out-of-range operands are not saturated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      z         <= '0;
    end else if (w_s2_load) begin
      out_valid <= r_s1_v;
      if (r_s1_v) begin
        z <= r_s1_diff[WIDTH] ? r_s1_wrap : r_s1_diff[WIDTH-1:0];
      end
    end
  end

`ifdef MOD_RANGE_CHECK_EN
  logic r_s1_err;
  logic w_range_err;

  assign w_range_err = (m != '0) && ((a >= m) || (b >= m));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_err <= 1'b0;
      err      <= 1'b0;
    end else begin
      if (w_s1_adv && in_valid) begin
        r_s1_err <= w_range_err;
      end
      if (w_s2_load && r_s1_v) begin
        err <= r_s1_err;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mod_sub_pipe.sv
// Scoreboard bench for mod_sub_pipe: directed vectors, back-to-back, backpressure, reset flush, random traffic.
module tb_mod_sub_pipe;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b, m;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] z;
`ifdef MOD_RANGE_CHECK_EN
  logic         err;
`endif

  mod_sub_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .m(m), .out_valid(out_valid), .out_ready(out_ready), .z(z)
`ifdef MOD_RANGE_CHECK_EN
    , .err(err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int z;
    int e;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input int act, input int expv);
    n_chk++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: if a >= b the plain difference, otherwise the difference plus m,
  // all taken modulo 2^W (so m=0 behaves as modulus 2^W).
  function automatic exp_t model(input int av, input int bv, input int mv);
    exp_t r;
    int d;
    d = av - bv;
    if (d < 0) d = d + mv;
    r.z = ((d % (1 << W)) + (1 << W)) % (1 << W);
    r.e = (mv != 0 && (av >= mv || bv >= mv)) ? 1 : 0;
    return r;
  endfunction

  // Monitor: pushes on every input transfer, pops on every output transfer.
  bit           stall_prev = 0;
  logic [W-1:0] held_z;
  int           held_e;

  always @(negedge clk) begin
    exp_t e;
    int   cur_e;
`ifdef MOD_RANGE_CHECK_EN
    cur_e = int'(err);
`else
    cur_e = 0;
`endif
    if (rst) begin
      exp_q.delete();
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_z", int'(z), int'(held_z));
`ifdef MOD_RANGE_CHECK_EN
        chk("hold_err", cur_e, held_e);
`endif
      end
      chk("in_ready_occupancy", int'(in_ready), (exp_q.size() < 2 || out_ready) ? 1 : 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("z", int'(z), e.z);
`ifdef MOD_RANGE_CHECK_EN
          chk("err", cur_e, e.e);
`endif
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(int'(a), int'(b), int'(m)));
      stall_prev = out_valid && !out_ready;
      held_z     = z;
      held_e     = cur_e;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit v, input int av, input int bv, input int mv);
    in_valid = v;
    a = av[W-1:0];
    b = bv[W-1:0];
    m = mv[W-1:0];
  endtask

  int accepted;
  int waited;

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    set_in(0, 0, 0, 0);
    #2;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_z", int'(z), 0);
`ifdef MOD_RANGE_CHECK_EN
    chk("reset_err", int'(err), 0);
`endif
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("in_ready_after_reset", int'(in_ready), 1);

    // Latency of two edges, single-cycle valid pulse
    set_in(1, 3, 5, 7);
    tick();
    set_in(0, 0, 0, 0);
    chk("lat_stage1_only", int'(out_valid), 0);
    tick();
    chk("lat_valid", int'(out_valid), 1);
    chk("lat_z", int'(z), 5);
    tick();
    chk("lat_pulse_end", int'(out_valid), 0);

    // Wrap, m=0 and out-of-range vectors
    set_in(1, 6, 2, 7);  tick();
    set_in(1, 1, 2, 0);  tick();
    set_in(1, 9, 1, 7);  tick();
    set_in(1, 15, 3, 4); tick();
    set_in(0, 0, 0, 0);
    repeat (3) tick();

    // Five back-to-back transfers, results on consecutive cycles
    for (int i = 0; i < 5; i++) begin
      set_in(1, $urandom_range(15), $urandom_range(15), $urandom_range(15));
      chk("b2b_in_ready", int'(in_ready), 1);
      tick();
      if (i >= 1) chk("b2b_out_valid", int'(out_valid), 1);
    end
    set_in(0, 0, 0, 0);
    tick();
    chk("b2b_last_valid", int'(out_valid), 1);
    tick();
    chk("b2b_drained", int'(out_valid), 0);

    // Backpressure for four cycles: exactly two accepted
    out_ready = 1'b0;
    accepted = 0;
    set_in(1, $urandom_range(15), $urandom_range(15), $urandom_range(15));
    for (int i = 0; i < 4; i++) begin
      if (in_ready) accepted++;
      tick();
      if (in_ready) set_in(1, $urandom_range(15), $urandom_range(15), $urandom_range(15));
    end
    chk("bp_accepted", accepted, 2);
    chk("bp_in_ready_low", int'(in_ready), 0);
    set_in(0, 0, 0, 0);
    out_ready = 1'b1;
    repeat (4) tick();
    chk("bp_drained_queue", exp_q.size(), 0);

    // Reset with two results in flight
    out_ready = 1'b0;
    set_in(1, 3, 5, 7); tick();
    set_in(1, 6, 2, 7); tick();
    set_in(0, 0, 0, 0);
    #1 rst = 1'b1;
    #1;
    chk("rst_async_valid", int'(out_valid), 0);
    chk("rst_async_z", int'(z), 0);
    tick(); tick();
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_no_stale", int'(out_valid), 0);
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(1), $urandom_range(15), $urandom_range(15), $urandom_range(15));
      out_ready = ($urandom_range(3) != 0);
      tick();
    end
    set_in(0, 0, 0, 0);
    out_ready = 1'b1;
    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      tick();
      waited++;
    end
    chk("final_drain", exp_q.size(), 0);
    tick();
    chk("final_idle", int'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
